// File: rtl/m_ext_issue_ctrl.sv
// EX-stage issue controller for the M-extension unit. It launches one operation at a time,
// stalls the pipeline until the result is ready, drains flushed operations and keeps a one-entry result cache.
module m_ext_issue_ctrl #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_mext,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1_data,
  input  logic [31:0] ex_rs2_data,
  input  logic        pipeline_advance,
  input  logic        flush,
  output logic        mext_stall,
  output logic [31:0] mext_result,
  output logic        mext_result_valid,
  output logic        unit_load,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [2:0]  unit_funct3,
  input  logic [31:0] unit_out,
  input  logic        unit_resp
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t      state_q;
  logic        issued_q;
  logic [31:0] a_q, b_q, res_q;
  logic [2:0]  f3_q;

  logic        cache_valid_q;
  logic [31:0] cache_a_q, cache_b_q, cache_res_q;
  logic [2:0]  cache_f3_q;

  logic req, cache_hit, resp_seen;

  assign req       = ex_valid & ex_is_mext & ~flush;
  assign cache_hit = CACHE_EN && cache_valid_q && (ex_rs1_data == cache_a_q)
                     && (ex_rs2_data == cache_b_q) && (ex_funct3 == cache_f3_q);
  // The unit may echo a stale resp during the load cycle, so only trust it once issued.
  assign resp_seen = issued_q & unit_resp;

  assign mext_result = res_q;
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign unit_funct3 = f3_q;

  always_comb begin
    mext_stall = 1'b0;
    case (state_q)
      IDLE:    mext_stall = req;
      BUSY:    mext_stall = 1'b1;
      DONE:    mext_stall = 1'b0;
      DRAIN:   mext_stall = req;
      default: mext_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      issued_q          <= 1'b0;
      a_q               <= '0;
      b_q               <= '0;
      f3_q              <= '0;
      res_q             <= '0;
      mext_result_valid <= 1'b0;
      unit_load         <= 1'b0;
      cache_valid_q     <= 1'b0;
      cache_a_q         <= '0;
      cache_b_q         <= '0;
      cache_f3_q        <= '0;
      cache_res_q       <= '0;
    end else begin
      unit_load <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            a_q  <= ex_rs1_data;
            b_q  <= ex_rs2_data;
            f3_q <= ex_funct3;
            if (cache_hit) begin
              res_q             <= cache_res_q;
              mext_result_valid <= 1'b1;
              state_q           <= DONE;
            end else begin
              issued_q  <= 1'b0;
              unit_load <= 1'b1;
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          issued_q <= 1'b1;
          // A flush that lands on the response cycle has nothing left to drain.
          if (flush) begin
            state_q <= resp_seen ? IDLE : DRAIN;
          end else if (resp_seen) begin
            res_q             <= unit_out;
            mext_result_valid <= 1'b1;
            state_q           <= DONE;
          end
        end
        DONE: begin
          if (pipeline_advance || flush) begin
            cache_valid_q     <= 1'b1;
            cache_a_q         <= a_q;
            cache_b_q         <= b_q;
            cache_f3_q        <= f3_q;
            cache_res_q       <= res_q;
            mext_result_valid <= 1'b0;
            state_q           <= IDLE;
          end
        end
        DRAIN: begin
          if (resp_seen) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_ext_issue_ctrl.sv
// Randomized and directed bench for m_ext_issue_ctrl. A transaction-level model predicts
// each operation's result, whether it hits the cache, and its stall/valid timeline.
module tb_m_ext_issue_ctrl;

  localparam bit CACHE_EN = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_mext, pipeline_advance, flush, unit_resp;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1_data, ex_rs2_data, unit_out;
  logic        mext_stall, mext_result_valid, unit_load;
  logic [31:0] mext_result, unit_a, unit_b;
  logic [2:0]  unit_funct3;

  int checks = 0;
  int errors = 0;
  int load_count = 0;

  bit          mc_valid;
  logic [31:0] mc_a, mc_b, mc_res;
  logic [2:0]  mc_f3;

  always #5 clk = ~clk;

  m_ext_issue_ctrl #(.CACHE_EN(CACHE_EN)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_mext(ex_is_mext),
    .ex_funct3(ex_funct3), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .pipeline_advance(pipeline_advance), .flush(flush), .mext_stall(mext_stall),
    .mext_result(mext_result), .mext_result_valid(mext_result_valid),
    .unit_load(unit_load), .unit_a(unit_a), .unit_b(unit_b), .unit_funct3(unit_funct3),
    .unit_out(unit_out), .unit_resp(unit_resp)
  );

  always @(posedge clk) if (unit_load === 1'b1) load_count <= load_count + 1;

  // RISC-V M-extension semantics, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input bit s, input bit l, input bit v);
    checkOutput({tag, ".stall"}, mext_stall, s);
    checkOutput({tag, ".load"}, unit_load, l);
    checkOutput({tag, ".valid"}, mext_result_valid, v);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_valid = 1'($urandom_range(0, 1)); ex_is_mext = 1'b0;
      pipeline_advance = 1'b0; flush = 1'b0; unit_resp = 1'b0;
      #1;
      checkCycle("idle", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic presentOp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    @(negedge clk);
    ex_valid = 1'b1; ex_is_mext = 1'b1; ex_funct3 = f3;
    ex_rs1_data = a; ex_rs2_data = b;
    pipeline_advance = 1'b0; flush = 1'b0; unit_resp = 1'b0;
    #1;
    checkCycle("capture", 1'b1, 1'b0, 1'b0);
  endtask

  // One full operation: capture, optional issue with unit latency lat, hold+1 DONE cycles.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                               input int lat, input int hold, input bit early, input bit end_flush);
    bit hit;
    logic [31:0] exp, ures;
    int l0;
    hit = CACHE_EN && mc_valid && mc_a == a && mc_b == b && mc_f3 == f3;
    exp = hit ? mc_res : m_ref(f3, a, b);
    l0 = load_count;
    presentOp(a, b, f3);
    ures = '0;
    if (!hit) begin
      @(negedge clk);
      unit_resp = early; unit_out = $urandom;
      #1;
      checkCycle("load", 1'b1, 1'b1, 1'b0);
      checkOutput("load.a", unit_a, a);
      checkOutput("load.b", unit_b, b);
      checkOutput("load.f3", 32'(unit_funct3), 32'(f3));
      ures = m_ref(unit_funct3, unit_a, unit_b);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        unit_resp = (k == lat); unit_out = (k == lat) ? ures : $urandom;
        #1;
        checkCycle("busy", 1'b1, 1'b0, 1'b0);
        checkOutput("busy.a", unit_a, a);
        checkOutput("busy.b", unit_b, b);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      unit_resp = 1'b0; unit_out = $urandom;
      if (h == hold) begin
        if (end_flush) flush = 1'b1; else pipeline_advance = 1'b1;
      end
      #1;
      checkCycle("done", 1'b0, 1'b0, 1'b1);
      checkOutput("done.result", mext_result, exp);
    end
    checkOutput("op.loads", 32'(load_count - l0), hit ? 32'd0 : 32'd1);
    mc_valid = 1'b1; mc_a = a; mc_b = b; mc_f3 = f3; mc_res = exp;
  endtask

  // Issue an op, flush it in BUSY cycle fb (1 = load cycle), optionally present the next op while draining.
  task automatic applyFlushed(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                              input int lat, input int fb, input bit with_next,
                              input logic [31:0] na, input logic [31:0] nb, input logic [2:0] nf3);
    logic [31:0] ures;
    int l0;
    l0 = load_count;
    ures = '0;
    presentOp(a, b, f3);
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      flush = (j == fb); pipeline_advance = 1'b0;
      if (j > fb) begin
        ex_valid = with_next; ex_is_mext = 1'b1;
        ex_rs1_data = na; ex_rs2_data = nb; ex_funct3 = nf3;
      end
      unit_resp = (j == lat + 1); unit_out = (j == lat + 1) ? ures : $urandom;
      #1;
      if (j == 1) begin
        ures = m_ref(unit_funct3, unit_a, unit_b);
        checkOutput("flush.a", unit_a, a);
        checkOutput("flush.b", unit_b, b);
      end
      checkCycle("flush", (j <= fb) ? 1'b1 : with_next, j == 1, 1'b0);
    end
    checkOutput("flush.loads", 32'(load_count - l0), 32'd1);
  endtask

  task automatic applyResetMidBusy(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    presentOp(a, b, f3);
    @(negedge clk); #1;
    checkCycle("rstbusy.load", 1'b1, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; ex_valid = 1'b0; #1;
    checkCycle("rstbusy.after", 1'b0, 1'b0, 1'b0);
    checkOutput("rstbusy.result", mext_result, 32'd0);
    checkOutput("rstbusy.a", unit_a, 32'd0);
    checkOutput("rstbusy.b", unit_b, 32'd0);
    checkOutput("rstbusy.f3", 32'(unit_funct3), 32'd0);
    mc_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, na, nb;
    logic [2:0]  f3, nf3;
    int lat, kind;
    rst = 1'b1; ex_valid = 1'b0; ex_is_mext = 1'b0; ex_funct3 = '0;
    ex_rs1_data = '0; ex_rs2_data = '0; pipeline_advance = 1'b0; flush = 1'b0;
    unit_resp = 1'b0; unit_out = '0; mc_valid = 1'b0;
    mc_a = '0; mc_b = '0; mc_f3 = '0; mc_res = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    checkCycle("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset.result", mext_result, 32'd0);
    checkOutput("reset.a", unit_a, 32'd0);
    checkOutput("reset.b", unit_b, 32'd0);
    checkOutput("reset.f3", 32'(unit_funct3), 32'd0);

    $display("[TB] directed sequence");
    applyStimulus(32'd7, 32'hFFFF_FFFD, 3'd0, 5, 0, 1'b0, 1'b0);
    applyStimulus(32'd7, 32'hFFFF_FFFD, 3'd0, 5, 0, 1'b0, 1'b0);
    applyStimulus(32'd100, 32'd7, 3'd5, 3, 0, 1'b0, 1'b0);
    applyFlushed(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 5, 3, 1'b1, 32'd10, 32'd0, 3'd6);
    applyStimulus(32'd10, 32'd0, 3'd6, 2, 0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 2, 0, 1'b0, 1'b0);
    applyStimulus(32'h1234, 32'h55, 3'd1, 2, 4, 1'b0, 1'b0);
    applyStimulus(32'h1234, 32'h55, 3'd1, 2, 0, 1'b0, 1'b0);
    applyResetMidBusy(32'd3, 32'd9, 3'd3);
    applyStimulus(32'd3, 32'd9, 3'd3, 2, 0, 1'b0, 1'b0);
    applyStimulus(32'hDEAD, 32'hBEEF, 3'd7, 1, 0, 1'b1, 1'b0);
    applyStimulus(32'hCAFE, 32'h0, 3'd4, 1, 1, 1'b0, 1'b1);
    applyStimulus(32'hCAFE, 32'h0, 3'd4, 1, 0, 1'b0, 1'b0);
    applyFlushed(32'd55, 32'd66, 3'd2, 3, 1, 1'b0, 32'd0, 32'd0, 3'd0);
    idleCycles(1);

    $display("[TB] random sequence");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0 && mc_valid) begin
        a = mc_a; b = mc_b; f3 = mc_f3;
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF) : $urandom;
        f3 = 3'($urandom_range(0, 7));
      end
      lat = $urandom_range(1, 4);
      kind = $urandom_range(0, 4);
      if (kind == 0 && !(mc_valid && mc_a == a && mc_b == b && mc_f3 == f3)) begin
        na = $urandom; nb = $urandom; nf3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) begin
          applyFlushed(a, b, f3, lat, $urandom_range(1, lat), 1'b1, na, nb, nf3);
          applyStimulus(na, nb, nf3, $urandom_range(1, 4), 0, 1'b0, 1'b0);
        end else begin
          applyFlushed(a, b, f3, lat, $urandom_range(1, lat), 1'b0, na, nb, nf3);
          idleCycles(1);
        end
      end else begin
        applyStimulus(a, b, f3, lat, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0));
      end
      idleCycles($urandom_range(0, 2));
    end
    idleCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_ext_issue_ctrl.md
Name: m_ext_issue_ctrl

Overview:
- EX-stage initiator for the M-extension unit: captures a MUL/DIV-class instruction, issues a one-cycle load and holds operands/funct3 stable until the unit responds.
- Stalls the pipeline while busy, then presents a registered result.
- Handles flushes of in-flight ops by draining the unit.
- Includes a single-entry result cache, so an identical repeated op completes without re-issuing.

Parameters:
- CACHE_EN, 1, enables the single-entry result cache (0 means every op issues to the unit).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  valid instruction in EX
- ex_is_mext  in  1  EX instruction is OP with funct7=0000001
- ex_funct3  in  3  M-extension funct3
- ex_rs1_data  in  32  operand a
- ex_rs2_data  in  32  operand b
- pipeline_advance  in  1  EX/MEM register loads this cycle
- flush  in  1  kill the instruction in EX
- mext_stall  out  1  hold IF/ID/EX
- mext_result  out  32  result to EX/MEM
- mext_result_valid  out  1  mext_result is valid this cycle
- unit_load  out  1  start pulse to the M unit
- unit_a  out  32  registered operand a
- unit_b  out  32  registered operand b
- unit_funct3  out  3  registered funct3
- unit_out  in  32  unit result
- unit_resp  in  1  unit done

Behaviour:
- Request: req = ex_valid & ex_is_mext & ~flush.
- States: IDLE, BUSY, DONE, DRAIN.
- Reset values: state=IDLE. All outputs are 0: stall, result, result_valid, unit_load, unit_a/b/funct3. Cache is invalid.
- IDLE:
  - On req, capture rs1/rs2/funct3 into a_q/b_q/f3_q and assert mext_stall=1 combinationally.
  - On a cache hit (CACHE_EN, cache valid, and a/b/funct3 all equal the cached values): res_q <= cache value, go to DONE.
  - Otherwise: go to BUSY with issued_q=0.
- BUSY:
  - unit_load=1 only in the first BUSY cycle (issued_q=0), then issued_q<=1.
  - unit_resp is sampled only when issued_q=1; resp in the load cycle is ignored.
  - On a sampled resp: res_q <= unit_out, go to DONE.
  - mext_stall=1 throughout.
  - unit_a/b/funct3 equal a_q/b_q/f3_q from the load cycle through the resp cycle.
- DONE:
  - mext_result=res_q, mext_result_valid=1, mext_stall=0.
  - On pipeline_advance or flush: go to IDLE. The cache is updated with {a_q,b_q,f3_q,res_q} in either case.
  - Otherwise stay in DONE, holding the result.
- Flush:
  - Flush in BUSY goes to DRAIN; this includes flush in the load cycle, where the load is still issued.
  - DRAIN waits for resp (sampled per the issued_q rule), discards unit_out, does not update the cache, then goes to IDLE.
  - In DRAIN, mext_stall = req; a new op waits and captures in IDLE afterwards.
  - Flush in IDLE: no capture.
- Stall outside IDLE/BUSY: mext_stall=0 when ~req.
  - In IDLE, stall is asserted in the capture cycle, so the minimum stall for a cache hit is 1 cycle.
  - Minimum stall for an issued op is 3 cycles with a unit latency of 1.
- unit_load is never asserted in IDLE, DONE or DRAIN. At most one op is outstanding.
- Boundary cases:
  - Back-to-back ops: the second is seen in IDLE the cycle after the DONE→IDLE advance.
  - rst mid-BUSY returns to IDLE immediately; the unit shares rst, so no drain is needed.
  - Divide-by-zero and overflow results are passed through unmodified.
  - Non-M funct3 values do not exist: all 8 are valid.

Test Plan:
- Functional MUL: MUL (f3=0) a=7, b=0xFFFFFFFD, unit model latency 5 → unit_load is exactly one pulse; mext_result=0xFFFFFFEB with valid=1; stall is high from capture until the DONE cycle; operands are stable throughout.
- Cache hit: repeat MUL 7 × 0xFFFFFFFD directly after → no unit_load; DONE the next cycle with 0xFFFFFFEB. Then DIVU a=100, b=7 → issues; result 14.
- Flush in BUSY: flush in the 3rd BUSY cycle of DIV a=0x80000000, b=0xFFFFFFFF → DRAIN. The REM (a=10, b=0) arriving during DRAIN stalls until resp, then issues; result 10. The cache does not hold the DIV.
- DONE hold: in DONE with pipeline_advance=0 for 4 cycles → result and valid held and stall=0; advance → IDLE; the cache is updated.
- Reset mid-BUSY: rst in BUSY → next cycle all outputs 0 and the cache is invalid. A repeat of the prior op issues a fresh unit_load.
- Resp timing: unit resp asserted in the load cycle is ignored; resp arriving one cycle later completes the op.
